// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write port between the printers and the UART transmitter FIFO
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    data;
  logic                          new_data;
  logic                          busy;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   level;

  modport master (output data, new_data, input busy, overflow, level);
  modport slave  (input data, new_data, output busy, overflow, level);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small byte FIFO
// Frames go out back-to-back while bytes are queued; block holds off new frames only.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           block,
  output logic           tx,
  uart_tx_fifo_if.slave  wr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          block_meta_q, block_meta_d;
  logic          block_sync_q, block_sync_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic full, can_pop, push, pop, ctr_done;

  always_comb begin
    full     = (level_q == LVL_FULL);
    can_pop  = (level_q != '0) && !block_sync_q;
    push     = wr.new_data && !full;
    ctr_done = (ctr_q == CTR_LAST);
    pop      = 1'b0;
    state_d  = state_q;
    ctr_d    = ctr_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;

    case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        tx_d  = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (ctr_done) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (ctr_done) begin
          ctr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (ctr_done) begin
          ctr_d = '0;
          // Chaining straight into START keeps back-to-back frames gap-free.
          if (can_pop) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    rd_d         = pop  ? rd_q + 1'b1 : rd_q;
    wr_d         = push ? wr_q + 1'b1 : wr_q;
    level_d      = level_q + LW'(push) - LW'(pop);
    overflow_d   = wr.new_data && full;
    block_meta_d = block;
    block_sync_d = block_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      rd_q         <= '0;
      wr_q         <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      block_meta_q <= 1'b0;
      block_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      block_meta_q <= block_meta_d;
      block_sync_q <= block_sync_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr.data;
  end

  assign tx          = tx_q;
  assign wr.busy     = full | block_sync_q;
  assign wr.overflow = overflow_q;
  assign wr.level    = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench with a serial receiver model
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic block = 1'b0;
  logic tx;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .block (block),
    .tx    (tx),
    .wr    (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Receiver model: detect start edge, sample each bit mid-cell.
  logic [7:0]  rx_q[$];
  int unsigned rx_t[$];
  int          rx_cnt = 0;
  int          frame_err = 0;
  bit          mon_busy = 1'b0;
  int          mon_off = 0;
  int unsigned mon_start = 0;
  logic [7:0]  mon_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx == 1'b0) begin
        mon_busy  = 1'b1;
        mon_off   = 0;
        mon_start = cyc;
      end
    end else begin
      mon_off++;
      if (mon_off % CPB == CPB / 2) begin
        if (mon_off / CPB == 0) begin
          if (tx !== 1'b0) frame_err++;
        end else if (mon_off / CPB <= 8) begin
          mon_byte[mon_off / CPB - 1] = tx;
        end else begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(mon_byte);
          rx_t.push_back(mon_start);
          rx_cnt++;
          mon_busy = 1'b0;
        end
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit expect_sent);
    bus.data     = b;
    bus.new_data = 1'b1;
    if (expect_sent) exp_q.push_back(b);
    @(negedge clk);
    bus.new_data = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int target, input int lim);
    int n = 0;
    while (rx_cnt < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx_cnt >= target, 1'b1);
  endtask

  task automatic drain(input string tag);
    logic [7:0] r;
    logic [15:0] e;
    while (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      e = (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 16'hdead;
      chk(tag, {8'h00, r}, e);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [FRAME-1:0] cap, expv;
    logic [7:0] b;
    int base, n, lows, sent, guard, ovf_cnt, busy_bad;

    bus.data = '0;
    bus.new_data = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_tx", tx, 1'b1);
    chk("rst_level", bus.level, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);

    // 1: single frame, exact waveform and latency
    b = 8'h55;
    bus.data = b; bus.new_data = 1'b1; exp_q.push_back(b);
    @(negedge clk);
    bus.new_data = 1'b0;
    chk("t1_tx_n1", tx, 1'b1);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      cap[i] = tx;
      expv[i] = (i / CPB == 0) ? 1'b0 : (i / CPB == 9) ? 1'b1 : b[i / CPB - 1];
      @(negedge clk);
    end
    chk("t1_lat", cap[0], 1'b0);
    chk("t1_frame", cap, expv);
    chk("t1_idle", tx, 1'b1);
    wait_rx("t1_rx_to", 1, 20);
    drain("t1_byte");
    tick(8);

    // 2: burst of six into depth-4 FIFO
    base = rx_cnt;
    for (int k = 1; k <= 6; k++) begin
      chk("t2_busy", bus.busy, k == 6);
      bus.data = 8'(k);
      bus.new_data = 1'b1;
      if (k <= 5) exp_q.push_back(8'(k));
      @(negedge clk);
    end
    bus.new_data = 1'b0;
    chk("t2_ovf_pulse", bus.overflow, 1'b1);
    chk("t2_level_full", bus.level, DEPTH);
    tick(1);
    chk("t2_ovf_clear", bus.overflow, 1'b0);
    wait_rx("t2_rx_to", base + 5, 5 * FRAME + 40);
    for (int i = 1; i < 5; i++)
      chk("t2_gap", rx_t[base + i] - rx_t[base + i - 1], FRAME);
    drain("t2_byte");
    tick(8);

    // 3: write while blocked, then release
    block = 1'b1;
    tick(3);
    chk("t3_busy_blk", bus.busy, 1'b1);
    send(8'ha5, 1'b1);
    tick(1);
    chk("t3_level", bus.level, 1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx == 1'b0) lows++;
      @(negedge clk);
    end
    chk("t3_tx_held", lows, 0);
    block = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (tx == 1'b0) break;
    end
    chk("t3_start_lat", (n >= 3 && n <= 4), 1'b1);
    chk("t3_busy_rel", bus.busy, 1'b0);
    wait_rx("t3_rx_to", rx_cnt + 1, FRAME + 10);
    drain("t3_byte");
    tick(8);

    // 4: block asserted mid-frame
    base = rx_cnt;
    send(8'h3c, 1'b1);
    send(8'h99, 1'b1);
    n = 0;
    while (tx != 1'b0 && n < 10) begin @(negedge clk); n++; end
    tick(10);
    block = 1'b1;
    tick(60);
    chk("t4_one_frame", rx_cnt, base + 1);
    chk("t4_level_held", bus.level, 1);
    chk("t4_tx_idle", tx, 1'b1);
    block = 1'b0;
    wait_rx("t4_rx_to", base + 2, FRAME + 20);
    drain("t4_byte");
    tick(8);

    // 5: reset during data bit 3 with two bytes queued
    base = rx_cnt;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t5_level_pre", bus.level, 2);
    tick(16);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_tx", tx, 1'b1);
    chk("t5_level", bus.level, 0);
    chk("t5_busy", bus.busy, 1'b0);
    tick(50);
    chk("t5_no_rx", rx_cnt, base);
    send(8'h7e, 1'b1);
    wait_rx("t5_rx_to", base + 1, FRAME + 10);
    drain("t5_byte");
    tick(8);

    // 6: sustained random traffic hovering around level 2
    base = rx_cnt;
    sent = 0; guard = 0; ovf_cnt = 0; busy_bad = 0;
    while (sent < 1000 && guard < 60000) begin
      if (bus.overflow) ovf_cnt++;
      if (bus.busy) busy_bad++;
      if (bus.level <= 2 && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        bus.data = b;
        bus.new_data = 1'b1;
        exp_q.push_back(b);
        sent++;
      end else begin
        bus.new_data = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.new_data = 1'b0;
    chk("t6_sent", sent, 1000);
    wait_rx("t6_rx_to", base + sent, 5 * FRAME + 20);
    if (bus.overflow) ovf_cnt++;
    chk("t6_ovf", ovf_cnt, 0);
    chk("t6_busy", busy_bad, 0);
    drain("t6_byte");

    chk("frame_err", frame_err, 0);
    chk("exp_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
